// File: rtl/spi_rx.sv
// SPI mode-0 receiver: synchronises scl/sda/cs, deserialises DATA_W bits MSB first, flags aborted frames.
// Latency SYNC_STAGES clk edges from scl capture to bit sample; no backpressure, valid/frame_err are strobes.
module spi_rx #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs,
    input  logic              scl,
    input  logic              sda,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              busy,
    output logic              frame_err
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic                   scl_q;
    logic                   scl_s;
    logic                   sda_s;
    logic                   cs_s;
    logic                   rise;
    logic [DATA_W-1:0]      shreg_nxt;

    state_t                 state_q;
    logic [CNT_W-1:0]       bit_cnt_q;
    logic [DATA_W-1:0]      shreg_q;
    logic [DATA_W-1:0]      data_out_q;
    logic                   valid_q;
    logic                   busy_q;
    logic                   frame_err_q;

    // cs resets high so a reset never looks like an active frame
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_sync_q <= '0;
            sda_sync_q <= '0;
            cs_sync_q  <= '1;
            scl_q      <= 1'b0;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda};
            cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], cs};
            scl_q      <= scl_s;
        end
    end

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign rise      = scl_s & ~scl_q;
    assign shreg_nxt = (shreg_q << 1) | DATA_W'(sda_s);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            data_out_q  <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    state_q <= ST_IDLE;
                    if (!cs_s && rise) begin
                        shreg_q   <= DATA_W'(sda_s);
                        bit_cnt_q <= CNT_W'(1);
                        busy_q    <= 1'b1;
                        state_q   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // deselect takes priority over a coincident scl rise
                    if (cs_s) begin
                        frame_err_q <= 1'b1;
                        shreg_q     <= '0;
                        bit_cnt_q   <= '0;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end else if (rise) begin
                        shreg_q <= shreg_nxt;
                        if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                            data_out_q <= shreg_nxt;
                            valid_q    <= 1'b1;
                            bit_cnt_q  <= '0;
                            busy_q     <= 1'b0;
                            state_q    <= ST_DONE;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out  = data_out_q;
    assign valid     = valid_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_rx.sv
// Bench for spi_rx: scoreboard of expected words checked on every valid strobe.
module tb_spi_rx;

    localparam int HALF = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cs;
    logic       scl;
    logic       sda;
    logic [7:0] data_out;
    logic       valid;
    logic       busy;
    logic       frame_err;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         valid_cnt = 0;
    int         ferr_cnt  = 0;
    int         spur_cnt  = 0;
    logic       watch_quiet = 1'b0;
    logic [7:0] exp_q[$];
    int         vt_q[$];

    spi_rx #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .reset    (rst_n),
        .cs       (cs),
        .scl      (scl),
        .sda      (sda),
        .data_out (data_out),
        .valid    (valid),
        .busy     (busy),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (watch_quiet && (valid || busy || frame_err)) spur_cnt++;
            if (frame_err) ferr_cnt++;
            if (valid) begin
                valid_cnt++;
                vt_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", {24'd0, data_out}, 32'hxx);
                end else begin
                    check("sb_word", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    // one scl period; caller is at a negedge with scl low
    task automatic send_bit(input logic b, input logic chk_lat);
        sda = b;
        repeat (HALF) @(negedge clk);
        scl = 1'b1;
        if (chk_lat) begin
            @(posedge clk);
            @(posedge clk);
            #1 check("lat_early", {31'd0, valid}, 32'd0);
            @(posedge clk);
            #1 check("lat_k2", {31'd0, valid}, 32'd1);
            @(negedge clk);
            repeat (HALF - 3) @(negedge clk);
        end else begin
            repeat (HALF) @(negedge clk);
        end
        scl = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input int nbits, input logic chk_lat);
        for (int i = 0; i < nbits; i++) begin
            send_bit(w[7-i], chk_lat && (i == 7));
        end
    endtask

    int v0, f0, n0;

    initial begin
        rst_n = 1'b0;
        cs    = 1'b1;
        scl   = 1'b0;
        sda   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data", {24'd0, data_out}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ferr", {31'd0, frame_err}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // single byte with latency check
        v0 = valid_cnt; f0 = ferr_cnt;
        cs = 1'b0;
        exp_q.push_back(8'hE2);
        send_word(8'hE2, 8, 1'b1);
        repeat (HALF) @(negedge clk);
        cs = 1'b1;
        repeat (10) @(negedge clk);
        check("single_valid_cnt", valid_cnt - v0, 1);
        check("single_ferr_cnt", ferr_cnt - f0, 0);
        check("single_data", {24'd0, data_out}, 32'hE2);

        // back-to-back without cs toggle
        v0 = valid_cnt; n0 = vt_q.size();
        cs = 1'b0;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h3C);
        send_word(8'hA5, 8, 1'b0);
        send_word(8'h3C, 8, 1'b0);
        repeat (HALF) @(negedge clk);
        cs = 1'b1;
        repeat (10) @(negedge clk);
        check("b2b_valid_cnt", valid_cnt - v0, 2);
        if (vt_q.size() >= n0 + 2) check("b2b_spacing", vt_q[n0+1] - vt_q[n0], 8 * 2 * HALF);
        else check("b2b_spacing_missing", vt_q.size() - n0, 2);

        // abort after 5 bits, then a clean word
        v0 = valid_cnt; f0 = ferr_cnt;
        cs = 1'b0;
        send_word(8'hFF, 5, 1'b0);
        check("abort_busy_pre", {31'd0, busy}, 32'd1);
        repeat (HALF) @(negedge clk);
        cs = 1'b1;
        repeat (10) @(negedge clk);
        check("abort_ferr_cnt", ferr_cnt - f0, 1);
        check("abort_valid_cnt", valid_cnt - v0, 0);
        check("abort_data_held", {24'd0, data_out}, 32'h3C);
        check("abort_busy_post", {31'd0, busy}, 32'd0);
        cs = 1'b0;
        exp_q.push_back(8'h81);
        send_word(8'h81, 8, 1'b0);
        repeat (HALF) @(negedge clk);
        cs = 1'b1;
        repeat (10) @(negedge clk);
        check("after_abort_data", {24'd0, data_out}, 32'h81);

        // reset mid-frame
        v0 = valid_cnt; f0 = ferr_cnt;
        cs = 1'b0;
        send_word(8'hF0, 4, 1'b0);
        check("rstmid_busy_pre", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstmid_data", {24'd0, data_out}, 32'd0);
        check("rstmid_busy", {31'd0, busy}, 32'd0);
        check("rstmid_valid", {31'd0, valid}, 32'd0);
        check("rstmid_ferr", {31'd0, frame_err}, 32'd0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        exp_q.push_back(8'h5A);
        send_word(8'h5A, 8, 1'b0);
        repeat (HALF) @(negedge clk);
        cs = 1'b1;
        repeat (10) @(negedge clk);
        check("rstmid_after_data", {24'd0, data_out}, 32'h5A);
        check("rstmid_ferr_cnt", ferr_cnt - f0, 0);
        check("rstmid_valid_cnt", valid_cnt - v0, 1);

        // deselected activity must be ignored
        spur_cnt = 0;
        watch_quiet = 1'b1;
        for (int i = 0; i < 16; i++) send_bit(1'b1, 1'b0);
        repeat (10) @(negedge clk);
        watch_quiet = 1'b0;
        check("desel_quiet", spur_cnt, 0);

        // cs rises together with the 8th scl rise
        v0 = valid_cnt; f0 = ferr_cnt;
        cs = 1'b0;
        send_word(8'hC3, 7, 1'b0);
        sda = 1'b1;
        repeat (HALF) @(negedge clk);
        scl = 1'b1;
        cs  = 1'b1;
        repeat (HALF) @(negedge clk);
        scl = 1'b0;
        repeat (10) @(negedge clk);
        check("coll_ferr_cnt", ferr_cnt - f0, 1);
        check("coll_valid_cnt", valid_cnt - v0, 0);
        check("coll_data_held", {24'd0, data_out}, 32'h5A);

        check("sb_drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
